ret_addr_stack: RTL



---
 rtl/ret_addr_stack.sv | 108 ++++++++++
 1 files changed

// File: rtl/ret_addr_stack.sv
// Return-address stack: CALL pushes pc+1 and redirects to target, RET pops into new_pc.
// Latency: one cycle, request sampled at edge N, new_pc/redirect valid after edge N.
// Backpressure: none; every cycle accepts a request. Optional RAS_OVERFLOW_WRAP_EN makes CALL-on-full overwrite the oldest entry.
module ret_addr_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          call_en,
  input  logic          ret_en,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] target_addr,
  input  logic          err_clr,
  output logic [AW-1:0] new_pc,
  output logic          redirect,
  output logic          empty,
  output logic          full,
  output logic          overflow_err,
  output logic          underflow_err,
  output logic          illegal_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem [DEPTH];
  logic [CW-1:0] count;
  // wr_ptr is the next free slot; the top of stack lives one slot below it.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] ptr_dec;

  logic illegal;
  logic do_call;
  logic do_ret;
  logic push;
  logic pop;
  logic ovf;
  logic unf;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Pointer neighbours with explicit wrap so non-power-of-two depths work.
  always_comb begin
    ptr_inc = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    ptr_dec = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - PW'(1);
  end

  // Request decode: simultaneous CALL and RET is rejected outright.
  always_comb begin
    illegal = call_en && ret_en;
    do_call = call_en && !ret_en;
    do_ret  = ret_en && !call_en;
    ovf     = do_call && full;
    unf     = do_ret && empty;
`ifdef RAS_OVERFLOW_WRAP_EN
    push    = do_call;
`else
    push    = do_call && !full;
`endif
    pop     = do_ret && !empty;
  end

  // Entry storage; on a wrapping overflow wr_ptr points at the oldest entry.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pc + AW'(1);
    end
  end

  // Pointer, occupancy, redirect output and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      count         <= '0;
      new_pc        <= '0;
      redirect      <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      illegal_err   <= 1'b0;
    end else begin
      redirect <= do_call || pop;
      if (do_call) begin
        new_pc <= target_addr;
      end else if (pop) begin
        new_pc <= mem[ptr_dec];
      end

      if (push) begin
        wr_ptr <= ptr_inc;
        if (!full) begin
          count <= count + CW'(1);
        end
      end else if (pop) begin
        wr_ptr <= ptr_dec;
        count  <= count - CW'(1);
      end

      // A fresh error in the clearing cycle keeps its flag set.
      overflow_err  <= (overflow_err  && !err_clr) || ovf;
      underflow_err <= (underflow_err && !err_clr) || unf;
      illegal_err   <= (illegal_err   && !err_clr) || illegal;
    end
  end

endmodule
